exec_vec_stage: RTL and testbench

//  Registered, parametrised vector execute stage for the filter-GPU pipeline: per-lane forwarding muxes,

---
 rtl/exec_pkg.sv | 36 +++
 rtl/exec_lane_alu.sv | 91 +++++++++
 rtl/exec_vec_stage.sv | 177 +++++++++++++++++
 tb/tb_exec_vec_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// ============================================================================
//  Module   : exec_pkg
//  Brief    : Shared types for the vector execute stage (ops, forward selects,
//             FSM states).
//  Revision : 1.0
// ============================================================================
`default_nettype none

package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RD     = 2'b00,
    FWD_WB     = 2'b01,
    FWD_MEM    = 2'b10,
    FWD_RD_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } exec_state_e;

endpackage

`default_nettype wire

// File: rtl/exec_lane_alu.sv
// ============================================================================
//  Module   : exec_lane_alu
//  Brief    : One execute lane: forwarding muxes, operand select, combinational
//             ALU and truncated multiply product.
//  Config   : EXEC_SAT_EN -- signed saturation on add/sub.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module exec_lane_alu
  import exec_pkg::*;
#(
  parameter int W = 18
) (
  input  logic [W-1:0] rd1_i,
  input  logic [W-1:0] rd2_i,
  input  logic [W-1:0] result_w_i,
  input  logic [W-1:0] alu_result_m_i,
  input  logic [W-1:0] ext_imm_i,
  input  logic [1:0]   fwd_a_i,
  input  logic [1:0]   fwd_b_i,
  input  logic [1:0]   alu_src_i,
  input  logic [2:0]   alu_ctrl_i,
  output logic [W-1:0] result_o,
  output logic [W-1:0] fwd_b_o
);

  logic [W-1:0] w_a_fwd;
  logic [W-1:0] w_b_fwd;
  logic [W-1:0] w_a_op;
  logic [W-1:0] w_b_op;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_add_res;
  logic [W-1:0] w_sub_res;
  logic [4:0]   w_shamt;
  logic         w_shift_big;

  always_comb begin
    case (fwd_sel_e'(fwd_a_i))
      FWD_WB:  w_a_fwd = result_w_i;
      FWD_MEM: w_a_fwd = alu_result_m_i;
      default: w_a_fwd = rd1_i;
    endcase
    case (fwd_sel_e'(fwd_b_i))
      FWD_WB:  w_b_fwd = result_w_i;
      FWD_MEM: w_b_fwd = alu_result_m_i;
      default: w_b_fwd = rd2_i;
    endcase
  end

  assign w_a_op      = alu_src_i[0] ? '0 : w_a_fwd;
  assign w_b_op      = alu_src_i[1] ? ext_imm_i : w_b_fwd;
  assign w_sum       = w_a_op + w_b_op;
  assign w_diff      = w_a_op - w_b_op;
  assign w_shamt     = w_b_op[4:0];
  assign w_shift_big = (int'(w_shamt) >= W);

`ifdef EXEC_SAT_EN
  localparam logic [W-1:0] c_sat_max = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] c_sat_min = {1'b1, {(W-1){1'b0}}};

  // Overflow: operand signs allow it and the result sign disagrees with A.
  assign w_add_res = ((w_a_op[W-1] == w_b_op[W-1]) && (w_sum[W-1] != w_a_op[W-1]))
                   ? (w_a_op[W-1] ? c_sat_min : c_sat_max) : w_sum;
  assign w_sub_res = ((w_a_op[W-1] != w_b_op[W-1]) && (w_diff[W-1] != w_a_op[W-1]))
                   ? (w_a_op[W-1] ? c_sat_min : c_sat_max) : w_diff;
`else
  assign w_add_res = w_sum;
  assign w_sub_res = w_diff;
`endif

  always_comb begin
    case (alu_op_e'(alu_ctrl_i))
      OP_ADD:  result_o = w_add_res;
      OP_SUB:  result_o = w_sub_res;
      OP_AND:  result_o = w_a_op & w_b_op;
      OP_OR:   result_o = w_a_op | w_b_op;
      OP_XOR:  result_o = w_a_op ^ w_b_op;
      OP_SHL:  result_o = w_shift_big ? '0 : (w_a_op << w_shamt);
      OP_SHR:  result_o = w_shift_big ? '0 : (w_a_op >> w_shamt);
      OP_MUL:  result_o = w_a_op * w_b_op;
      default: result_o = '0;
    endcase
  end

  assign fwd_b_o = w_b_fwd;

endmodule

`default_nettype wire

// File: rtl/exec_vec_stage.sv
// ============================================================================
//  Module   : exec_vec_stage
//  Brief    : Registered LANES-wide execute stage with multi-cycle multiply,
//             valid/ready handshake and neighbour address generation.
//  Config   : EXEC_SAT_EN -- signed saturation on add/sub (in exec_lane_alu).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module exec_vec_stage
  import exec_pkg::*;
#(
  parameter int W       = 18,
  parameter int LANES   = 3,
  parameter int ADDR_W  = 19,
  parameter int STRIDE  = 1,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LANES*W-1:0]   rd1_i,
  input  logic [LANES*W-1:0]   rd2_i,
  input  logic [LANES*W-1:0]   result_w_i,
  input  logic [LANES*W-1:0]   alu_result_m_i,
  input  logic [LANES*W-1:0]   ext_imm_i,
  input  logic [1:0]           fwd_a_i,
  input  logic [1:0]           fwd_b_i,
  input  logic [1:0]           alu_src_i,
  input  logic [2:0]           alu_ctrl_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LANES*W-1:0]   alu_result_o,
  output logic [LANES*W-1:0]   write_data_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [ADDR_W-1:0]    addr_p_o,
  output logic [ADDR_W-1:0]    addr_m_o
);

  localparam int         c_vec_w       = LANES * W;
  localparam int         c_cnt_w       = $clog2(MUL_LAT);
  localparam logic [0:0] c_st_idle     = IDLE;
  localparam logic [0:0] c_st_mul_busy = MUL_BUSY;

  logic [0:0]         state_q,     state_d;
  logic [c_cnt_w-1:0] cnt_q,       cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [c_vec_w-1:0] res_q,       res_d;
  logic [c_vec_w-1:0] wd_q,        wd_d;
  logic [c_vec_w-1:0] pend_res_q,  pend_res_d;
  logic [c_vec_w-1:0] pend_wd_q,   pend_wd_d;
  logic [ADDR_W-1:0]  addr_q,      addr_d;
  logic [ADDR_W-1:0]  addr_p_q,    addr_p_d;
  logic [ADDR_W-1:0]  addr_m_q,    addr_m_d;

  logic [c_vec_w-1:0] w_lane_res;
  logic [c_vec_w-1:0] w_lane_wd;
  logic [c_vec_w-1:0] w_load_res;
  logic [c_vec_w-1:0] w_load_wd;
  logic               w_load;
  logic               w_accept;
  logic               w_is_mul;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exec_lane_alu #(.W(W)) u_alu (
      .rd1_i          (rd1_i[g*W +: W]),
      .rd2_i          (rd2_i[g*W +: W]),
      .result_w_i     (result_w_i[g*W +: W]),
      .alu_result_m_i (alu_result_m_i[g*W +: W]),
      .ext_imm_i      (ext_imm_i[g*W +: W]),
      .fwd_a_i        (fwd_a_i),
      .fwd_b_i        (fwd_b_i),
      .alu_src_i      (alu_src_i),
      .alu_ctrl_i     (alu_ctrl_i),
      .result_o       (w_lane_res[g*W +: W]),
      .fwd_b_o        (w_lane_wd[g*W +: W])
    );
  end

  assign in_ready_o = !rst && (state_q == c_st_idle) && (!out_valid_q || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o && !flush_i;
  assign w_is_mul   = (alu_ctrl_i == OP_MUL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    pend_res_d  = pend_res_q;
    pend_wd_d   = pend_wd_q;
    w_load      = 1'b0;
    w_load_res  = w_lane_res;
    w_load_wd   = w_lane_wd;
    if (flush_i) begin
      state_d     = c_st_idle;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready_i) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        c_st_idle: begin
          if (w_accept) begin
            if (w_is_mul) begin
              // Operands are captured at accept so the inputs may change while busy.
              state_d    = c_st_mul_busy;
              cnt_d      = c_cnt_w'(MUL_LAT - 1);
              pend_res_d = w_lane_res;
              pend_wd_d  = w_lane_wd;
            end else begin
              w_load = 1'b1;
            end
          end
        end
        c_st_mul_busy: begin
          if (cnt_q == c_cnt_w'(1)) begin
            w_load     = 1'b1;
            w_load_res = pend_res_q;
            w_load_wd  = pend_wd_q;
            state_d    = c_st_idle;
          end else begin
            cnt_d = cnt_q - c_cnt_w'(1);
          end
        end
        default: state_d = c_st_idle;
      endcase
      if (w_load) begin
        out_valid_d = 1'b1;
      end
    end
  end

  // Lane 0 fills the low address bits, lane 1 supplies the remaining high bits.
  assign res_d    = w_load ? w_load_res : res_q;
  assign wd_d     = w_load ? w_load_wd : wd_q;
  assign addr_d   = w_load ? w_load_res[ADDR_W-1:0] : addr_q;
  assign addr_p_d = w_load ? (w_load_res[ADDR_W-1:0] + ADDR_W'(STRIDE)) : addr_p_q;
  assign addr_m_d = w_load ? (w_load_res[ADDR_W-1:0] - ADDR_W'(STRIDE)) : addr_m_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_st_idle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      wd_q        <= '0;
      pend_res_q  <= '0;
      pend_wd_q   <= '0;
      addr_q      <= '0;
      addr_p_q    <= '0;
      addr_m_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      wd_q        <= wd_d;
      pend_res_q  <= pend_res_d;
      pend_wd_q   <= pend_wd_d;
      addr_q      <= addr_d;
      addr_p_q    <= addr_p_d;
      addr_m_q    <= addr_m_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign alu_result_o = res_q;
  assign write_data_o = wd_q;
  assign addr_o       = addr_q;
  assign addr_p_o     = addr_p_q;
  assign addr_m_o     = addr_m_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_vec_stage.sv
// ============================================================================
//  Module   : tb_exec_vec_stage
//  Brief    : Scoreboard bench for exec_vec_stage with directed vectors.
//  Config   : EXEC_SAT_EN selects saturating expectations for add/sub.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exec_vec_stage;
  import exec_pkg::*;

  localparam int W = 18;
  localparam int LANES = 3;
  localparam int ADDR_W = 19;
  localparam int VW = LANES * W;
  localparam logic [W-1:0] Z = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [VW-1:0] rd1 = '0, rd2 = '0, result_w = '0, alu_result_m = '0, ext_imm = '0;
  logic [1:0] fwd_a = '0, fwd_b = '0, alu_src = '0;
  logic [2:0] alu_ctrl = '0;
  logic [VW-1:0] alu_result, write_data;
  logic [ADDR_W-1:0] addr, addr_p, addr_m;

  typedef struct packed {
    logic [VW-1:0]     res;
    logic [VW-1:0]     wd;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] ap;
    logic [ADDR_W-1:0] am;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  exec_vec_stage #(.W(W), .LANES(LANES), .ADDR_W(ADDR_W), .STRIDE(1), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rd1_i(rd1), .rd2_i(rd2), .result_w_i(result_w), .alu_result_m_i(alu_result_m),
    .ext_imm_i(ext_imm), .fwd_a_i(fwd_a), .fwd_b_i(fwd_b), .alu_src_i(alu_src),
    .alu_ctrl_i(alu_ctrl), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_result_o(alu_result), .write_data_o(write_data),
    .addr_o(addr), .addr_p_o(addr_p), .addr_m_o(addr_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] splat(input logic [W-1:0] v);
    return {v, v, v};
  endfunction

  function automatic exp_t mk(input logic [VW-1:0] r, input logic [VW-1:0] w,
                              input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] ap,
                              input logic [ADDR_W-1:0] am);
    exp_t e;
    e.res = r; e.wd = w; e.a = a; e.ap = ap; e.am = am;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [1:0] src, input logic [VW-1:0] r1, input logic [VW-1:0] r2,
                       input logic [VW-1:0] rw, input logic [VW-1:0] rm, input logic [VW-1:0] imm,
                       input bit push, input exp_t e);
    alu_ctrl = op; fwd_a = fa; fwd_b = fb; alu_src = src;
    rd1 = r1; rd2 = r2; result_w = rw; alu_result_m = rm; ext_imm = imm;
    in_valid = 1'b1;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) in_valid = 1'b0;
    check("accept", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_valid(input string nm, input int want_lat);
    int lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1 && want_lat > 1) check({nm, "_busy_in_ready"}, {63'd0, in_ready}, 64'd0);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check({nm, "_latency"}, 64'(lat), 64'(want_lat));
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [1:0] src, input logic [VW-1:0] r1,
                       input logic [VW-1:0] r2, input logic [VW-1:0] rw, input logic [VW-1:0] rm,
                       input logic [VW-1:0] imm, input exp_t e, input int want_lat);
    step();
    drive(op, fa, fb, src, r1, r2, rw, rm, imm, 1'b1, e);
    wait_accept();
    wait_valid(nm, want_lat);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got=0x%0h want=none", alu_result);
        end else begin
          e = sb.pop_front();
          check("alu_result", 64'(alu_result), 64'(e.res));
          check("write_data", 64'(write_data), 64'(e.wd));
          check("addr", 64'(addr), 64'(e.a));
          check("addr_p", 64'(addr_p), 64'(e.ap));
          check("addr_m", 64'(addr_m), 64'(e.am));
        end
      end
    end
  end

  initial begin : stim
    exp_t none;
    none = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_alu_result", 64'(alu_result), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_addr_p", 64'(addr_p), 64'd0);
    check("rst_addr_m", 64'(addr_m), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Forward A from MEM, B from rd2: 7 + 3
    issue("add_fwd", OP_ADD, 2'b10, 2'b00, 2'b00, splat(18'd5), splat(18'd3), splat(18'd100),
          splat(18'd7), splat(18'd50),
          mk(splat(18'd10), splat(18'd3), 19'd10, 19'd11, 19'd9), 1);

    // A forced to zero, OR passes B; address wrap at top of range
    issue("addr_wrap", OP_OR, 2'b00, 2'b00, 2'b01, splat(18'h2AAAA),
          {18'h00155, 18'h00001, 18'h3FFFF}, splat(Z), splat(Z), splat(Z),
          mk({18'h00155, 18'h00001, 18'h3FFFF}, {18'h00155, 18'h00001, 18'h3FFFF},
             19'h7FFFF, 19'h00000, 19'h7FFFE), 1);

    // A from WB, B via select 11 (= rd2)
    issue("and_fwd", OP_AND, 2'b01, 2'b11, 2'b00, splat(18'h11111), splat(18'h0F0F0),
          splat(18'h3C3C3), splat(18'h22222), splat(Z),
          mk(splat(18'h0C0C0), splat(18'h0F0F0), 19'h0C0C0, 19'h0C0C1, 19'h0C0BF), 1);

    // Shift amounts 17 / 18 / 31 from the immediate
    issue("shl", OP_SHL, 2'b00, 2'b00, 2'b10, splat(18'd1), splat(18'd7), splat(Z), splat(Z),
          {18'd31, 18'd18, 18'd17},
          mk({18'd0, 18'd0, 18'h20000}, splat(18'd7), 19'h20000, 19'h20001, 19'h1FFFF), 1);
    issue("shr", OP_SHR, 2'b00, 2'b00, 2'b10, splat(18'h3FFFF), splat(18'd7), splat(Z), splat(Z),
          {18'd18, 18'd17, 18'd4},
          mk({18'd0, 18'd1, 18'h03FFF}, splat(18'd7), 19'h43FFF, 19'h44000, 19'h43FFE), 1);

    // Multiply latency and truncation
    issue("mul", OP_MUL, 2'b00, 2'b00, 2'b00, splat(18'd300), splat(18'd400), splat(Z),
          splat(Z), splat(Z),
          mk(splat(18'd120000), splat(18'd400), 19'd120000, 19'd120001, 19'd119999), 3);
    issue("mul_trunc", OP_MUL, 2'b00, 2'b00, 2'b00, splat(18'd512), splat(18'd512), splat(Z),
          splat(Z), splat(Z),
          mk(splat(18'd0), splat(18'd512), 19'd0, 19'd1, 19'h7FFFF), 3);

    // Backpressure: output held, no new accept
    step();
    out_ready = 1'b0;
    drive(OP_XOR, 2'b00, 2'b00, 2'b10, splat(18'h0F0F0), splat(18'h12345), splat(Z), splat(Z),
          splat(18'h00FF0), 1'b1,
          mk(splat(18'h0FF00), splat(18'h12345), 19'h0FF00, 19'h0FF01, 19'h0FEFF));
    wait_accept();
    drive(OP_SUB, 2'b00, 2'b00, 2'b00, splat(18'd100), splat(18'd30), splat(Z), splat(Z),
          splat(Z), 1'b1, mk(splat(18'd70), splat(18'd30), 19'd70, 19'd71, 19'd69));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_alu_result", 64'(alu_result), 64'(splat(18'h0FF00)));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept();
    wait_valid("drain", 1);

    // Flush in idle drops a same-cycle input
    step();
    flush = 1'b1;
    drive(OP_ADD, 2'b00, 2'b00, 2'b00, splat(18'd1), splat(18'd1), splat(Z), splat(Z), splat(Z),
          1'b0, none);
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_out_valid", {63'd0, out_valid}, 64'd0);

    // Flush in the second busy cycle aborts the multiply
    step();
    drive(OP_MUL, 2'b00, 2'b00, 2'b00, splat(18'd9), splat(18'd9), splat(Z), splat(Z), splat(Z),
          1'b0, none);
    wait_accept();
    @(posedge clk);
    #1 flush = 1'b1;
    drive(OP_ADD, 2'b00, 2'b00, 2'b00, splat(18'd2), splat(18'd2), splat(Z), splat(Z), splat(Z),
          1'b0, none);
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_mul_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_mul_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_mul_quiet", {63'd0, out_valid}, 64'd0);
    end

    // Async reset mid-multiply
    step();
    drive(OP_MUL, 2'b00, 2'b00, 2'b00, splat(18'd3), splat(18'd3), splat(Z), splat(Z), splat(Z),
          1'b0, none);
    wait_accept();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mul_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mul_alu_result", 64'(alu_result), 64'd0);
    check("rst_mul_addr", 64'(addr), 64'd0);
    check("rst_mul_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mul_quiet", {63'd0, out_valid}, 64'd0);
    end

    // Signed boundary on add/sub
`ifdef EXEC_SAT_EN
    issue("add_edge", OP_ADD, 2'b00, 2'b00, 2'b00, splat(18'h1FFFF), splat(18'd1), splat(Z),
          splat(Z), splat(Z),
          mk(splat(18'h1FFFF), splat(18'd1), 19'h5FFFF, 19'h60000, 19'h5FFFE), 1);
    issue("sub_edge", OP_SUB, 2'b00, 2'b00, 2'b00, splat(18'h20000), splat(18'd1), splat(Z),
          splat(Z), splat(Z),
          mk(splat(18'h20000), splat(18'd1), 19'h20000, 19'h20001, 19'h1FFFF), 1);
`else
    issue("add_edge", OP_ADD, 2'b00, 2'b00, 2'b00, splat(18'h1FFFF), splat(18'd1), splat(Z),
          splat(Z), splat(Z),
          mk(splat(18'h20000), splat(18'd1), 19'h20000, 19'h20001, 19'h1FFFF), 1);
    issue("sub_edge", OP_SUB, 2'b00, 2'b00, 2'b00, splat(18'h20000), splat(18'd1), splat(Z),
          splat(Z), splat(Z),
          mk(splat(18'h1FFFF), splat(18'd1), 19'h5FFFF, 19'h60000, 19'h5FFFE), 1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
